// File: rtl/risc16_dbus_ctrl_if.sv
// CPU-side data bus of the RISC16 data-bus controller.
// The CPU (master) drives address, write data, and strobes; the controller (slave) returns read data and dready.
interface risc16_dbus_ctrl_if;
  localparam int unsigned DW = 16;

  logic [DW-1:0] daddr;
  logic [DW-1:0] ddout;
  logic          doe;
  logic          dwe0;
  logic          dwe1;
  logic [DW-1:0] ddin;
  logic          dready;

  modport master (output daddr, ddout, doe, dwe0, dwe1, input ddin, dready);
  modport slave  (input daddr, ddout, doe, dwe0, dwe1, output ddin, dready);
endinterface

// File: rtl/risc16_dbus_ctrl.sv
// RISC16 data-bus controller: routes CPU accesses to sync RAM (2-cycle reads) or IO regs at 0x0200-0x020F.
// Optional 32-bit cycle timer at 0x0204/0x0206 is enabled by the RISC16_DBUS_TIMER_EN macro.
module risc16_dbus_ctrl (
  input  logic                     clk,
  input  logic                     rst_n,
  risc16_dbus_ctrl_if.slave        bus,
  output logic [14:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  output logic [1:0]               mem_we,
  output logic                     mem_oe,
  input  logic [15:0]              mem_rdata,
  output logic [23:0]              led
);
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 15;
  localparam int unsigned LW  = 24;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   led_q, led_d;
  logic            wr, io;
  logic [DW-1:0]   io_rdata;
  logic [DW-1:0]   ddin_c;
  logic            dready_c;
  logic [AW-1:0]   mem_addr_c;
  logic [1:0]      mem_we_c;
  logic            mem_oe_c;

`ifdef RISC16_DBUS_TIMER_EN
  logic [31:0]     cnt_q;
  logic [DW-1:0]   hi_q;
  logic            cnt_clr, hi_ld;
`endif

  assign wr = bus.dwe0 | bus.dwe1;
  assign io = (bus.daddr[15:4] == 12'h020);

  // IO register read mux; odd byte addresses alias their word
  always_comb begin
    io_rdata = '0;
    case (bus.daddr[3:0])
      4'h0, 4'h1: io_rdata = led_q[15:0];
      4'h2, 4'h3: io_rdata = {8'h00, led_q[23:16]};
`ifdef RISC16_DBUS_TIMER_EN
      4'h4, 4'h5: io_rdata = cnt_q[15:0];
      4'h6, 4'h7: io_rdata = hi_q;
`endif
      default:    io_rdata = '0;
    endcase
  end

  // Next-state and bus-response decode; a write always wins over a read
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    led_d      = led_q;
    ddin_c     = '0;
    dready_c   = 1'b0;
    mem_addr_c = bus.daddr[15:1];
    mem_we_c   = 2'b00;
    mem_oe_c   = 1'b0;
`ifdef RISC16_DBUS_TIMER_EN
    cnt_clr    = 1'b0;
    hi_ld      = 1'b0;
`endif
    if (wr) begin
      dready_c = 1'b1;
      state_d  = IDLE;
      if (!io) begin
        mem_we_c = {bus.dwe0, bus.dwe1};
      end else begin
        case (bus.daddr[3:0])
          4'h0, 4'h1: begin
            if (bus.dwe0) led_d[15:8] = bus.ddout[15:8];
            if (bus.dwe1) led_d[7:0]  = bus.ddout[7:0];
          end
          4'h2, 4'h3: begin
            if (bus.dwe1) led_d[23:16] = bus.ddout[7:0];
          end
`ifdef RISC16_DBUS_TIMER_EN
          4'h4, 4'h5: cnt_clr = 1'b1;
`endif
          default: ;
        endcase
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.doe) begin
            if (io) begin
              dready_c = 1'b1;
              ddin_c   = io_rdata;
`ifdef RISC16_DBUS_TIMER_EN
              hi_ld    = (bus.daddr[3:1] == 3'd2);
`endif
            end else begin
              mem_oe_c = 1'b1;
              addr_d   = bus.daddr[15:1];
              state_d  = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          mem_addr_c = addr_q;
          state_d    = IDLE;
          if (bus.doe) begin
            dready_c = 1'b1;
            ddin_c   = mem_rdata;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset forces the bus response quiet immediately, not just at the next edge
  assign bus.ddin   = rst_n ? ddin_c   : '0;
  assign bus.dready = rst_n & dready_c;
  assign mem_we     = rst_n ? mem_we_c : 2'b00;
  assign mem_oe     = rst_n & mem_oe_c;
  assign mem_addr   = mem_addr_c;
  assign mem_wdata  = bus.ddout;
  assign led        = led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      led_q   <= led_d;
    end
  end

`ifdef RISC16_DBUS_TIMER_EN
  // Free-running cycle counter; high half snapshotted when the low half is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
    end else begin
      cnt_q <= cnt_clr ? 32'd0 : cnt_q + 32'd1;
      if (hi_ld) hi_q <= cnt_q[31:16];
    end
  end
`endif

endmodule

// File: tb/tb_risc16_dbus_ctrl.sv
// Self-checking bench for risc16_dbus_ctrl: vector table plus reset, abort and timer sequences.
module tb_risc16_dbus_ctrl;
  logic        clk;
  logic        rst_n;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_we;
  logic        mem_oe;
  logic [15:0] mem_rdata;
  logic [23:0] led;

  int checks = 0;
  int errors = 0;

  risc16_dbus_ctrl_if bus ();

  risc16_dbus_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_rdata (mem_rdata),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous RAM with byte enables; read data one cycle after mem_oe
  logic [15:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we[1]) ram[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
    if (mem_we[0]) ram[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
    if (mem_oe)    mem_rdata <= ram[mem_addr[7:0]];
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        oe;
    logic        we0;
    logic        we1;
    logic [15:0] exp_ddin;
    logic        exp_rdy;
    logic        exp_oe;
    logic [1:0]  exp_we;
    logic        chk_addr;
    logic [14:0] exp_maddr;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [15:0] a, input logic [15:0] d, input logic oe, input logic w0,
                     input logic w1, input logic [15:0] xd, input logic xr, input logic xo,
                     input logic [1:0] xw, input logic ca, input logic [14:0] xa, input logic [23:0] xl);
    vec_t v;
    v.addr = a; v.wdata = d; v.oe = oe; v.we0 = w0; v.we1 = w1;
    v.exp_ddin = xd; v.exp_rdy = xr; v.exp_oe = xo; v.exp_we = xw;
    v.chk_addr = ca; v.exp_maddr = xa; v.exp_led = xl;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic oe,
                       input logic w0, input logic w1);
    bus.daddr = a; bus.ddout = d; bus.doe = oe; bus.dwe0 = w0; bus.dwe1 = w1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    mem_rdata = 16'h0000;
    rst_n = 1'b0;

    //   addr      wdata     oe w0 w1  ddin      rdy oe  we     ca maddr     led
    add(16'h0200, 16'hABCD, 0, 1, 1, 16'h0000, 1, 0, 2'b00, 0, 15'h0000, 24'h000000);
    add(16'h0202, 16'h0012, 0, 0, 1, 16'h0000, 1, 0, 2'b00, 0, 15'h0000, 24'h00ABCD);
    add(16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'h0200, 16'h0000, 1, 0, 0, 16'hABCD, 1, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'h0202, 16'h0000, 1, 0, 0, 16'h0012, 1, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'h0208, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'h0202, 16'hFF77, 0, 1, 0, 16'h0000, 1, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'h0202, 16'h0000, 1, 0, 0, 16'h0012, 1, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'hC000, 16'h1234, 0, 1, 1, 16'h0000, 1, 0, 2'b11, 1, 15'h6000, 24'h12ABCD);
    add(16'hC000, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 2'b00, 1, 15'h6000, 24'h12ABCD);
    add(16'hC000, 16'h0000, 1, 0, 0, 16'h1234, 1, 0, 2'b00, 1, 15'h6000, 24'h12ABCD);
    add(16'hC002, 16'hBEEF, 0, 1, 1, 16'h0000, 1, 0, 2'b11, 1, 15'h6001, 24'h12ABCD);
    add(16'hC002, 16'hAA55, 0, 0, 1, 16'h0000, 1, 0, 2'b01, 1, 15'h6001, 24'h12ABCD);
    add(16'hC002, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 2'b00, 1, 15'h6001, 24'h12ABCD);
    add(16'hC002, 16'h0000, 1, 0, 0, 16'hBE55, 1, 0, 2'b00, 1, 15'h6001, 24'h12ABCD);
    add(16'hC000, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 2'b00, 1, 15'h6000, 24'h12ABCD);
    add(16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'h0200, 16'h0000, 1, 0, 0, 16'hABCD, 1, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'hC004, 16'h0099, 1, 0, 1, 16'h0000, 1, 0, 2'b01, 1, 15'h6002, 24'h12ABCD);
    add(16'hC004, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 2'b00, 1, 15'h6002, 24'h12ABCD);
    add(16'hC004, 16'h0000, 1, 0, 0, 16'h0099, 1, 0, 2'b00, 1, 15'h6002, 24'h12ABCD);
    add(16'h0200, 16'h5500, 0, 1, 0, 16'h0000, 1, 0, 2'b00, 0, 15'h0000, 24'h12ABCD);
    add(16'h0201, 16'h0000, 1, 0, 0, 16'h55CD, 1, 0, 2'b00, 0, 15'h0000, 24'h1255CD);
    add(16'h020E, 16'h1111, 0, 1, 1, 16'h0000, 1, 0, 2'b00, 0, 15'h0000, 24'h1255CD);
    add(16'h0200, 16'h0000, 1, 0, 0, 16'h55CD, 1, 0, 2'b00, 0, 15'h0000, 24'h1255CD);

    // Reset holds the bus response quiet even with strobes active
    drive(16'hC000, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rst_dready", 32'(bus.dready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_oe", 32'(mem_oe), 32'd0);
    chk("rst_ddin", 32'(bus.ddin), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    repeat (2) @(negedge clk);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].addr, vt[i].wdata, vt[i].oe, vt[i].we0, vt[i].we1);
      #1;
      chk($sformatf("v%0d_ddin", i), 32'(bus.ddin), 32'(vt[i].exp_ddin));
      chk($sformatf("v%0d_dready", i), 32'(bus.dready), 32'(vt[i].exp_rdy));
      chk($sformatf("v%0d_mem_oe", i), 32'(mem_oe), 32'(vt[i].exp_oe));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].exp_we));
      chk($sformatf("v%0d_led", i), 32'(led), 32'(vt[i].exp_led));
      if (vt[i].chk_addr) chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].exp_maddr));
      if (vt[i].we0 | vt[i].we1) chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vt[i].wdata));
    end

`ifndef RISC16_DBUS_TIMER_EN
    // Timer addresses behave as unmapped IO
    @(negedge clk); drive(16'h0204, 16'h0000, 1'b1, 1'b0, 1'b0); #1;
    chk("notimer_0204_ddin", 32'(bus.ddin), 32'd0);
    chk("notimer_0204_rdy", 32'(bus.dready), 32'd1);
    @(negedge clk); drive(16'h0206, 16'h0000, 1'b1, 1'b0, 1'b0); #1;
    chk("notimer_0206_ddin", 32'(bus.ddin), 32'd0);
`else
    // Clear timer, wait 0x1_0005 cycles, read both halves as one snapshot
    @(negedge clk); drive(16'h0204, 16'hFFFF, 1'b0, 1'b1, 1'b0); #1;
    chk("tmr_clr_rdy", 32'(bus.dready), 32'd1);
    chk("tmr_clr_we", 32'(mem_we), 32'd0);
    @(negedge clk); drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (32'h10005) @(negedge clk);
    drive(16'h0204, 16'h0000, 1'b1, 1'b0, 1'b0); #1;
    chk("tmr_lo", 32'(bus.ddin), 32'h0005);
    chk("tmr_lo_rdy", 32'(bus.dready), 32'd1);
    @(negedge clk); drive(16'h0206, 16'h0000, 1'b1, 1'b0, 1'b0); #1;
    chk("tmr_hi", 32'(bus.ddin), 32'h0001);
`endif

    // Reset asserted mid-RD_WAIT aborts the read; next access starts from IDLE
    @(negedge clk); drive(16'hC000, 16'h0000, 1'b1, 1'b0, 1'b0); #1;
    chk("rw_enter_oe", 32'(mem_oe), 32'd1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rw_rst_dready", 32'(bus.dready), 32'd0);
    chk("rw_rst_ddin", 32'(bus.ddin), 32'd0);
    chk("rw_rst_led", 32'(led), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rw_idle_oe", 32'(mem_oe), 32'd1);
    chk("rw_idle_rdy", 32'(bus.dready), 32'd0);
    @(negedge clk); #1;
    chk("rw_done_rdy", 32'(bus.dready), 32'd1);
    chk("rw_done_ddin", 32'(bus.ddin), 32'h1234);
    @(negedge clk); drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/risc16_dbus_ctrl.md
RISC16_DBUS_CTRL -- requirements
Module: risc16_dbus_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port daddr, input, 16, CPU byte address.
REQ-004 SHALL have port ddout, input, 16, CPU write data, bits [15:8] are the even byte and bits [7:0] the odd byte (big-endian).
REQ-005 SHALL have port doe, input, 1, CPU read request.
REQ-006 SHALL have ports dwe0 and dwe1, input, 1 each; dwe0 writes the even (high) byte, dwe1 writes the odd (low) byte.
REQ-007 SHALL have port ddin, output, 16, read data to CPU.
REQ-008 SHALL have port dready, output, 1, access complete this cycle.
REQ-009 SHALL have port mem_addr, output, 15, word address to synchronous RAM.
REQ-010 SHALL have ports mem_wdata (output, 16), mem_we (output, 2; bit1 = high byte, bit0 = low byte), mem_oe (output, 1) and mem_rdata (input, 16; valid one cycle after mem_oe).
REQ-011 SHALL have port led, output, 24, LED register {led2, led1, led0}.

Function
REQ-012 SHALL decode the IO window as 0x0200-0x020F; all other addresses SHALL map to RAM with mem_addr = daddr[15:1].
REQ-013 SHALL give a write priority over a read when dwe0/dwe1 and doe are asserted in the same cycle; doe SHALL be ignored in that cycle.
REQ-014 RAM write: mem_we = {dwe0, dwe1}, mem_wdata = ddout, dready = 1 in the same cycle; writes SHALL never target RAM when the address is in the IO window.
REQ-015 0x0200 write: dwe0 SHALL load led[15:8] from ddout[15:8]; dwe1 SHALL load led[7:0] from ddout[7:0].
REQ-016 0x0202 write: dwe1 SHALL load led[23:16] from ddout[7:0]; dwe0 SHALL be ignored.
REQ-017 Writes to unmapped IO addresses SHALL be discarded with dready = 1.
REQ-018 Read FSM states SHALL be IDLE and RD_WAIT.
REQ-019 IDLE + doe + RAM address: mem_oe = 1, dready = 0, next state RD_WAIT.
REQ-020 RD_WAIT + doe held: ddin = mem_rdata, dready = 1, next state IDLE; the read latency is therefore 2 cycles.
REQ-021 RD_WAIT + doe dropped (abort): dready = 0, next state IDLE, data discarded.
REQ-022 The CPU SHALL hold daddr stable from doe assertion until dready; the block SHALL latch daddr on entry to RD_WAIT and use the latched value.
REQ-023 IO read: ddin = register value and dready = 1 in the same cycle; the FSM SHALL stay in IDLE.
REQ-024 0x0200 SHALL read {led[15:8], led[7:0]}; 0x0202 SHALL read {8'h00, led[23:16]}; unmapped IO SHALL read 16'h0000.
REQ-025 ddin SHALL be 16'h0000 whenever dready = 0 or no read is in progress.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, led = 24'h000000, dready = 0, mem_oe = 0, mem_we = 2'b00, ddin = 0, timer and latch = 0.
REQ-027 A reset asserted during RD_WAIT SHALL abort the read; after release the block SHALL accept a new access from IDLE.

Configuration
REQ-028 Macro RISC16_DBUS_TIMER_EN defined SHALL include a 32-bit free-running cycle counter, +1 per clock, wrapping 0xFFFFFFFF -> 0.
REQ-029 With RISC16_DBUS_TIMER_EN: a 0x0204 read SHALL return counter[15:0] and latch counter[31:16]; a 0x0206 read SHALL return the latched value; any byte write to 0x0204 SHALL clear the counter to 0 on the next edge.
REQ-030 Without RISC16_DBUS_TIMER_EN: no counter logic SHALL exist, and 0x0204/0x0206 SHALL behave as unmapped IO.

Verification
REQ-031 Write 0xABCD to 0x0200 with dwe0 = dwe1 = 1, then write 0x0012 to 0x0202 with dwe1 -> led = 0x12ABCD and mem_we stays 0.
REQ-032 Write 0x1234 to 0xC000 (both bytes), then doe at 0xC000 -> dready low for 1 cycle, then ddin = 0x1234 with dready = 1.
REQ-033 Write 0xAA55 to 0xC002 with dwe1 only -> mem_we = 2'b01; a subsequent read returns the old high byte and 0x55 in the low byte.
REQ-034 doe at 0xC000 for one cycle, then drop -> FSM returns to IDLE with no dready; the next IO read of 0x0200 completes in 1 cycle.
REQ-035 doe and dwe1 together at 0xC004 -> write performed, mem_oe = 0, dready = 1.
REQ-036 With RISC16_DBUS_TIMER_EN: write to 0x0204, wait 0x1_0005 cycles, read 0x0204 then 0x0206 -> the reads return low and high halves consistent with one snapshot (high half = 0x0001); assert rst_n mid-RD_WAIT -> led = 0 and the FSM is in IDLE.
